// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data, data priority with fetch anti-starvation
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 8,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WIDTH-1:0]  if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WIDTH-1:0]  dm_wdata,
  output logic [WIDTH-1:0]  dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              grant_dm,
  output logic              busy,
  output logic              stall_if,
  output logic              stall_dm
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] wait_cnt;
  logic [2:0] starve_cnt;
  logic pick_if;
  assign pick_if = if_req & (~dm_req | (starve_cnt == 3'(STARVE_MAX)));
  assign busy = state != IDLE;
  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      starve_cnt <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      grant_dm <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: if (if_req | dm_req) begin
          state <= ISSUE;
          mem_en <= 1'b1;
          grant_dm <= ~pick_if;
          mem_we <= ~pick_if & dm_we;
          mem_addr <= pick_if ? if_addr : dm_addr;
          mem_wdata <= pick_if ? '0 : dm_wdata;
          starve_cnt <= pick_if ? 3'd0 : (if_req && starve_cnt != 3'(STARVE_MAX)) ? starve_cnt + 3'd1 : starve_cnt;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          wait_cnt <= 4'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (wait_cnt == 4'd0) begin
          state <= RESP;
          if_rdata <= (!grant_dm && !mem_we) ? mem_rdata : if_rdata;
          dm_rdata <= (grant_dm && !mem_we) ? mem_rdata : dm_rdata;
          if_ready <= ~grant_dm;
          dm_ready <= grant_dm;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single shared memory port between the pipeline's instruction-fetch stage and its data-memory stage. Each stage sees a request/ready handshake; the backing memory is single-ported with a fixed read latency. The block arbitrates with data priority plus an anti-starvation counter for fetch. It also produces per-port stall flags that feed the hazard logic.

## Interface
- WIDTH, 32, data word width
- ADDR_W, 8, memory address width
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal 1..15)
- STARVE_MAX, 2, consecutive data grants while fetch waits before fetch is forced (legal 1..7)

- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request, held high until if_ready
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  WIDTH  fetched word, registered
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request, held high until dm_ready
- dm_we  input  1  1 = write, 0 = read
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  WIDTH  write data
- dm_rdata  output  WIDTH  load data, registered
- dm_ready  output  1  one-cycle completion pulse for data
- mem_en  output  1  memory access strobe, registered
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_W  memory address, registered
- mem_wdata  output  WIDTH  memory write data, registered
- mem_rdata  input  WIDTH  memory read data
- grant_dm  output  1  1 = current or last transaction is data
- busy  output  1  state != IDLE
- stall_if  output  1  if_req & ~if_ready (combinational)
- stall_dm  output  1  dm_req & ~dm_ready (combinational)

## Operation
- States:
  - IDLE → ISSUE when any request is sampled.
  - ISSUE: 1 cycle → WAIT.
  - WAIT: MEM_LAT cycles → RESP.
  - RESP: 1 cycle → IDLE.
- IDLE, arbitration:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - On grant, the selected address, we and wdata are latched into the mem_* registers. Fetch always uses mem_we = 0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on a data grant while if_req is high.
  - Clears on any fetch grant.
- ISSUE: mem_en = 1 (mem_we per grant) for exactly one cycle; mem_en = 0 in all other states.
- Final WAIT cycle (mem_rdata valid):
  - Read: capture mem_rdata into the granted port's rdata register.
  - Write: leave dm_rdata unchanged.
  - The non-granted port's rdata is never modified.
- RESP: pulse the granted port's ready for one cycle. Requests present during RESP are ignored; the requester is still holding its completed req.
- A req dropped mid-transaction does not abort it: the transaction completes and ready still pulses.
- rst, including mid-transaction:
  - State returns to IDLE; starve_cnt = 0.
  - All registered outputs clear to 0: if_rdata, dm_rdata, mem_*, ready pulses, grant_dm.
  - An in-flight access produces no ready pulse; its late memory data is discarded.

## Timing
- Reset values: every output is 0. stall_* follow their inputs combinationally.
- Timeline, request first sampled in IDLE at cycle 0:
  - mem_en high in cycle 1.
  - mem_rdata sampled in cycle 1+MEM_LAT.
  - ready high in cycle 2+MEM_LAT.
  - Fetch latency = MEM_LAT+2.
- Throughput: one transaction per MEM_LAT+3 cycles. Back-to-back grants are separated by the RESP and IDLE cycles.
- A request held across a RESP of the other port is sampled in the following IDLE cycle.
- mem_addr, mem_wdata and mem_we hold their values after ISSUE until the next grant.

## Test plan
- Single fetch, MEM_LAT=2: if_req at cycle 0 with if_addr=0x10; memory returns 0x2002000A.
  - Required: mem_en=1 with mem_addr=0x10 in cycle 1 only.
  - Required: if_ready pulse in cycle 4 with if_rdata=0x2002000A.
  - Required: stall_if=1 in cycles 0–3.
- Simultaneous requests: if_req and dm_req (read 0x04) at cycle 0.
  - Required: dm_ready in cycle 4.
  - Required: fetch mem_en in cycle 6 and if_ready in cycle 9.
  - Required: starve_cnt=1, then 0 after the fetch grant.
- Starvation, STARVE_MAX=2: both requests held continuously.
  - Required grant order: dm, dm, if, dm, dm, if.
- Write: dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF, with dm_rdata previously 0x5.
  - Required: mem_en=mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF in cycle 1.
  - Required: dm_ready in cycle 4 with dm_rdata still 0x5.
- Reset mid-WAIT: fetch issued, rst high in cycle 2.
  - Required: cycle 3 has all outputs 0, and no if_ready follows.
  - Required: a new if_req at cycle 5 completes in cycle 9.
- MEM_LAT=1 sweep: a single read completes with ready in cycle 3, and the rdata capture is correct.
